// File: rtl/sync_up_counter_pkg.sv
// Shared types and helpers for the synchronous modulo-N up counter.
// Latency: n/a (declarations only).
// Backpressure: n/a (no flow control in this block).
package sync_up_counter_pkg;

  // Priority-decoded operation for one clock edge (clear > load > inc > hold).
  typedef enum logic [1:0] {
    CNT_OP_HOLD  = 2'd0,
    CNT_OP_INC   = 2'd1,
    CNT_OP_LOAD  = 2'd2,
    CNT_OP_CLEAR = 2'd3
  } cnt_op_t;

  // Saturate a requested load value to the last legal count.
  // Done at 32 bits so a single helper serves every counter width.
  function automatic logic [31:0] clamp_load(input logic [31:0] val,
                                             input logic [31:0] max_cnt);
    return (val > max_cnt) ? max_cnt : val;
  endfunction

endpackage

// File: rtl/sync_up_counter_nxt.sv
// Next-state decode for sync_up_counter: picks the op and computes next count/flags.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller registers the outputs every edge.
module sync_up_counter_nxt
  import sync_up_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic [WIDTH-1:0] count,
  input  logic             en,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output cnt_op_t          op,
  output logic [WIDTH-1:0] count_nxt,
  output logic             wrap_nxt,
  output logic             load_err_nxt
);

  localparam logic [WIDTH-1:0] MAX_CNT   = WIDTH'(MODULUS - 1);
  localparam logic [31:0]      MAX_CNT32 = 32'(MODULUS - 1);

  logic [WIDTH:0]   inc_w;
  logic             roll;
  logic [WIDTH-1:0] load_clamped;
  logic             load_bad;

  // Increment one bit wider than the count so the carry is never silently lost.
  assign inc_w = {1'b0, count} + {{WIDTH{1'b0}}, 1'b1};

  // Wrap is decided by the terminal compare; the carry term only matters if the
  // count were ever all-ones, and folding it in keeps such a state from sticking.
  assign roll = (count == MAX_CNT) | inc_w[WIDTH];

  assign load_clamped = WIDTH'(clamp_load(32'(load_val), MAX_CNT32));
  assign load_bad     = (32'(load_val) > MAX_CNT32);

  // Priority decode of the edge operation and the values it produces.
  always_comb begin
    op           = CNT_OP_HOLD;
    count_nxt    = count;
    wrap_nxt     = 1'b0;
    load_err_nxt = 1'b0;
    if (clear) begin
      op        = CNT_OP_CLEAR;
      count_nxt = '0;
    end else if (load) begin
      op           = CNT_OP_LOAD;
      count_nxt    = load_clamped;
      load_err_nxt = load_bad;
    end else if (en) begin
      op        = CNT_OP_INC;
      count_nxt = roll ? '0 : inc_w[WIDTH-1:0];
      wrap_nxt  = roll;
    end
  end

endmodule

// File: rtl/sync_up_counter.sv
// Fully synchronous modulo-N up counter with clear/load/enable, tc and wrap; optional sticky overflow (SYNC_UP_COUNTER_OVF_STICKY_EN).
// Latency: count/wrap/load_err/ovf_sticky register 1 cycle after the edge; tc is combinational (0 cycles).
// Backpressure: none; en acts as the advance qualifier and tc feeds the next stage's en when cascading.
module sync_up_counter
  import sync_up_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef SYNC_UP_COUNTER_OVF_STICKY_EN
  input  logic             ovf_ack,
  output logic             ovf_sticky,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  cnt_op_t          op;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic             load_err_nxt;

  sync_up_counter_nxt #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_nxt (
    .count        (count),
    .en           (en),
    .clear        (clear),
    .load         (load),
    .load_val     (load_val),
    .op           (op),
    .count_nxt    (count_nxt),
    .wrap_nxt     (wrap_nxt),
    .load_err_nxt (load_err_nxt)
  );

  // Count register: only touched when the decoded op actually changes it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (op != CNT_OP_HOLD) begin
      count <= count_nxt;
    end
  end

  // Single-cycle status pulses, recomputed every edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= wrap_nxt;
      load_err <= load_err_nxt;
    end
  end

  // Terminal count is zero-latency so a downstream stage advances on the same edge.
  assign tc = en & (count == MAX_CNT);

`ifdef SYNC_UP_COUNTER_OVF_STICKY_EN
  // Sticky overflow: clear dominates, a fresh wrap beats a simultaneous ack.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf_sticky <= 1'b0;
    end else if (op == CNT_OP_CLEAR) begin
      ovf_sticky <= 1'b0;
    end else if (wrap_nxt) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_ack) begin
      ovf_sticky <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_sync_up_counter.sv
// Scoreboard bench: driver pushes model results per edge, monitor pops and compares.
// Latency: one expected entry per posedge plus one per asynchronous reset assertion.
// Backpressure: n/a.
module tb_sync_up_counter;

  typedef struct {
    int cnt;
    bit wrap;
    bit err;
    bit tc;
    bit sticky;
  } mstate_t;

  typedef struct {
    mstate_t a;       // MODULUS=10 instance
    mstate_t b;       // MODULUS=16 instance
    int      tot;     // cascaded composite value
    bit      lo_wrap;
    bit      hi_wrap;
    bit      hi_tc;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       en10, clr10, ld10;
  logic [3:0] lv10;
  logic       en16, clr16, ld16, ack16;
  logic [3:0] lv16;
  logic       c_en;

  logic [3:0] c10, c16, clo, chi;
  logic       tc10, tc16, tclo, tchi;
  logic       wr10, wr16, wrlo, wrhi;
  logic       le10, le16, lelo, lehi;
`ifdef SYNC_UP_COUNTER_OVF_STICKY_EN
  logic       st10, st16, stlo, sthi;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];
  event rst_ev;

  mstate_t m10, m16;
  int      tot;
  bit      lo_wrap_m, hi_wrap_m, hi_tc_m;

  always #5 clock = ~clock;

  sync_up_counter #(.WIDTH(4), .MODULUS(10)) u10 (
    .clock(clock), .reset(reset), .en(en10), .clear(clr10), .load(ld10), .load_val(lv10),
`ifdef SYNC_UP_COUNTER_OVF_STICKY_EN
    .ovf_ack(1'b0), .ovf_sticky(st10),
`endif
    .count(c10), .tc(tc10), .wrap(wr10), .load_err(le10)
  );

  sync_up_counter #(.WIDTH(4), .MODULUS(16)) u16 (
    .clock(clock), .reset(reset), .en(en16), .clear(clr16), .load(ld16), .load_val(lv16),
`ifdef SYNC_UP_COUNTER_OVF_STICKY_EN
    .ovf_ack(ack16), .ovf_sticky(st16),
`endif
    .count(c16), .tc(tc16), .wrap(wr16), .load_err(le16)
  );

  sync_up_counter #(.WIDTH(4), .MODULUS(16)) u_lo (
    .clock(clock), .reset(reset), .en(c_en), .clear(1'b0), .load(1'b0), .load_val(4'd0),
`ifdef SYNC_UP_COUNTER_OVF_STICKY_EN
    .ovf_ack(1'b0), .ovf_sticky(stlo),
`endif
    .count(clo), .tc(tclo), .wrap(wrlo), .load_err(lelo)
  );

  sync_up_counter #(.WIDTH(4), .MODULUS(16)) u_hi (
    .clock(clock), .reset(reset), .en(tclo), .clear(1'b0), .load(1'b0), .load_val(4'd0),
`ifdef SYNC_UP_COUNTER_OVF_STICKY_EN
    .ovf_ack(1'b0), .ovf_sticky(sthi),
`endif
    .count(chi), .tc(tchi), .wrap(wrhi), .load_err(lehi)
  );

  // Behavioural rule set for one counter edge.
  function automatic mstate_t model_next(input mstate_t s, input int m, input bit clr,
                                         input bit ld, input int lv, input bit en,
                                         input bit ack);
    mstate_t n;
    n = s;
    n.wrap = 1'b0;
    n.err  = 1'b0;
    if (clr) begin
      n.cnt    = 0;
      n.sticky = 1'b0;
    end else if (ld) begin
      n.cnt = (lv < m) ? lv : m - 1;
      n.err = (lv >= m);
    end else if (en) begin
      n.cnt  = (s.cnt + 1) % m;
      n.wrap = (n.cnt == 0);
    end
    if (!clr) begin
      if (n.wrap) n.sticky = 1'b1;
      else if (ack) n.sticky = 1'b0;
    end
    n.tc = en && (n.cnt == m - 1);
    return n;
  endfunction

  task automatic zero_model();
    m10 = '{0, 1'b0, 1'b0, 1'b0, 1'b0};
    m16 = '{0, 1'b0, 1'b0, 1'b0, 1'b0};
    tot = 0;
    lo_wrap_m = 1'b0;
    hi_wrap_m = 1'b0;
    hi_tc_m   = 1'b0;
  endtask

  task automatic push();
    exp_t e;
    e.a = m10;
    e.b = m16;
    e.tot = tot;
    e.lo_wrap = lo_wrap_m;
    e.hi_wrap = hi_wrap_m;
    e.hi_tc   = hi_tc_m;
    q.push_back(e);
  endtask

  // Advance the model over the coming posedge using the inputs now applied.
  task automatic step();
    bit lo_tc;
    if (!reset) begin
      zero_model();
    end else begin
      m10 = model_next(m10, 10, clr10, ld10, int'(lv10), en10, 1'b0);
      m16 = model_next(m16, 16, clr16, ld16, int'(lv16), en16, ack16);
      lo_wrap_m = c_en && (tot % 16 == 15);
      hi_wrap_m = c_en && (tot == 255);
      if (c_en) tot = (tot + 1) % 256;
      lo_tc   = c_en && (tot % 16 == 15);
      hi_tc_m = lo_tc && (tot / 16 == 15);
    end
    push();
  endtask

  task automatic cyc();
    step();
    @(negedge clock);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: every posedge (and asynchronous reset assertion) presents a new output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock or rst_ev);
      #1;
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard at %0t: output with no expected entry, queue size 0 (need >= 1)", $time);
      end else begin
        e = q.pop_front();
        chk("u10.count",    32'(c10),  32'(e.a.cnt));
        chk("u10.wrap",     32'(wr10), 32'(e.a.wrap));
        chk("u10.load_err", 32'(le10), 32'(e.a.err));
        chk("u10.tc",       32'(tc10), 32'(e.a.tc));
        chk("u16.count",    32'(c16),  32'(e.b.cnt));
        chk("u16.wrap",     32'(wr16), 32'(e.b.wrap));
        chk("u16.load_err", 32'(le16), 32'(e.b.err));
        chk("u16.tc",       32'(tc16), 32'(e.b.tc));
`ifdef SYNC_UP_COUNTER_OVF_STICKY_EN
        chk("u16.ovf_sticky", 32'(st16), 32'(e.b.sticky));
`endif
        chk("casc.lo_count", 32'(clo),  32'(e.tot % 16));
        chk("casc.hi_count", 32'(chi),  32'(e.tot / 16));
        chk("casc.lo_wrap",  32'(wrlo), 32'(e.lo_wrap));
        chk("casc.hi_wrap",  32'(wrhi), 32'(e.hi_wrap));
        chk("casc.hi_tc",    32'(tchi), 32'(e.hi_tc));
      end
    end
  end

  // Driver: inputs change on negedges, one expected entry per upcoming posedge.
  initial begin
    reset = 1'b0;
    en10 = 1'b1; clr10 = 1'b0; ld10 = 1'b0; lv10 = 4'd0;
    en16 = 1'b1; clr16 = 1'b0; ld16 = 1'b0; lv16 = 4'd0; ack16 = 1'b0;
    c_en = 1'b1;
    zero_model();

    // Held in reset with enables high: everything stays at 0.
    repeat (3) cyc();

    // MODULUS=10 free run from 0 through a wrap.
    reset = 1'b1;
    en16  = 1'b0;
    repeat (12) cyc();

    // Out-of-range load saturates and flags; in-range load does not.
    en10 = 1'b0; ld10 = 1'b1; lv10 = 4'd12;
    cyc();
    lv10 = 4'd5;
    cyc();
    ld10 = 1'b0;
    cyc();

    // Load beats increment at 15; clear beats load and increment.
    ld16 = 1'b1; lv16 = 4'd15;
    cyc();
    en16 = 1'b1; lv16 = 4'd3;
    cyc();
    clr16 = 1'b1;
    cyc();
    clr16 = 1'b0; ld16 = 1'b0; en16 = 1'b0;
    cyc();

    // Sticky overflow: set by wrap, ack coinciding with a wrap loses, lone ack clears.
    ld16 = 1'b1; lv16 = 4'd15;
    cyc();
    ld16 = 1'b0; en16 = 1'b1;
    cyc();
    en16 = 1'b0; ld16 = 1'b1;
    cyc();
    ld16 = 1'b0; en16 = 1'b1; ack16 = 1'b1;
    cyc();
    en16 = 1'b0;
    cyc();
    ack16 = 1'b0;
    cyc();

    // Asynchronous reset mid-count (u16 at 7): zero before the next edge, held while low.
    ld16 = 1'b1; lv16 = 4'd7;
    cyc();
    ld16 = 1'b0; en16 = 1'b1; en10 = 1'b1;
    #2;
    zero_model();
    push();
    reset = 1'b0;
    -> rst_ev;
    step();
    @(negedge clock);
    cyc();
    cyc();

    // Cascade from 0 through a full 256-count roll-over.
    reset = 1'b1;
    en10 = 1'b0; en16 = 1'b0; c_en = 1'b1;
    repeat (260) cyc();

    // Random mix of all controls.
    repeat (400) begin
      clr10 = ($urandom_range(0, 15) == 0);
      ld10  = ($urandom_range(0, 7) == 0);
      lv10  = 4'($urandom_range(0, 15));
      en10  = ($urandom_range(0, 3) != 0);
      clr16 = ($urandom_range(0, 15) == 0);
      ld16  = ($urandom_range(0, 7) == 0);
      lv16  = 4'($urandom_range(0, 15));
      en16  = ($urandom_range(0, 3) != 0);
      ack16 = ($urandom_range(0, 3) == 0);
      c_en  = ($urandom_range(0, 7) != 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
